// File: rtl/fifo_wide_wr_narrow_rd.sv
// Single-clock asymmetric FIFO: stores WR_WIDTH-bit words and returns them as RATIO
// narrow lanes, lowest lane first, through a registered read port.
module fifo_wide_wr_narrow_rd #(
  parameter  int WR_WIDTH = 32,
  parameter  int RATIO    = 4,
  localparam int RD_WIDTH = WR_WIDTH / RATIO,
  parameter  int WR_DEPTH = 1024,
  localparam int LVL_W    = $clog2(WR_DEPTH * RATIO) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wce,
  input  logic [WR_WIDTH-1:0] wd,
  output logic                full,
  input  logic                rce,
  output logic [RD_WIDTH-1:0] rq,
  output logic                rvalid,
  output logic                empty,
  output logic [LVL_W-1:0]    level,
  output logic                err_ovf,
  output logic                err_udf
);

  localparam int AW = $clog2(WR_DEPTH);
  localparam int LW = $clog2(RATIO);

  localparam logic [AW:0]       PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]       PTR_FULL  = (AW + 1)'(WR_DEPTH);
  localparam logic [LW-1:0]     LANE_ONE  = LW'(1);
  localparam logic [LW-1:0]     LANE_LAST = LW'(RATIO - 1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_RATIO = LVL_W'(RATIO);

  logic [WR_WIDTH-1:0] mem [WR_DEPTH];

  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_word_q, rd_word_d;
  logic [LW-1:0]       rd_lane_q, rd_lane_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [RD_WIDTH-1:0] rq_q, rq_d;
  logic                rvalid_q, rvalid_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_udf_q, err_udf_d;

  logic [AW:0]         word_occ;
  logic                wr_acc;
  logic                rd_acc;
  logic [WR_WIDTH-1:0] rd_word_data;
  logic [RD_WIDTH-1:0] rd_lane_data;

  // A partially consumed word still holds its slot until its last lane is read.
  assign word_occ = wr_ptr_q - rd_word_q;
  assign full     = (word_occ == PTR_FULL);
  assign empty    = (level_q == '0);
  assign wr_acc   = wce && !full;
  assign rd_acc   = rce && !empty;

  assign rd_word_data = mem[rd_word_q[AW-1:0]];
  assign rd_lane_data = rd_word_data[rd_lane_q * RD_WIDTH +: RD_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= wd;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_word_d = rd_word_q;
    rd_lane_d = rd_lane_q;
    level_d   = level_q;
    rq_d      = rq_q;
    rvalid_d  = rd_acc;
    err_ovf_d = err_ovf_q | (wce & full);
    err_udf_d = err_udf_q | (rce & empty);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_acc) begin
      rq_d = rd_lane_data;
      if (rd_lane_q == LANE_LAST) begin
        rd_lane_d = '0;
        rd_word_d = rd_word_q + PTR_ONE;
      end else begin
        rd_lane_d = rd_lane_q + LANE_ONE;
      end
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_RATIO;
      2'b01:   level_d = level_q - LVL_ONE;
      2'b11:   level_d = level_q + LVL_RATIO - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_word_q <= '0;
      rd_lane_q <= '0;
      level_q   <= '0;
      rq_q      <= '0;
      rvalid_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_word_q <= rd_word_d;
      rd_lane_q <= rd_lane_d;
      level_q   <= level_d;
      rq_q      <= rq_d;
      rvalid_q  <= rvalid_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign rq      = rq_q;
  assign rvalid  = rvalid_q;
  assign level   = level_q;
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: tb/tb_fifo_wide_wr_narrow_rd.sv
// Randomised bench for fifo_wide_wr_narrow_rd against a lane-queue reference model.
module tb_fifo_wide_wr_narrow_rd;

  localparam int WR_WIDTH = 32;
  localparam int RATIO    = 4;
  localparam int RD_WIDTH = 8;
  localparam int WR_DEPTH = 1024;
  localparam int LVL_W    = 13;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wce = 1'b0;
  logic [WR_WIDTH-1:0] wd = '0;
  logic                rce = 1'b0;
  logic                full, rvalid, empty, err_ovf, err_udf;
  logic [RD_WIDTH-1:0] rq;
  logic [LVL_W-1:0]    level;

  fifo_wide_wr_narrow_rd #(
    .WR_WIDTH(WR_WIDTH),
    .RATIO   (RATIO),
    .WR_DEPTH(WR_DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wce    (wce),
    .wd     (wd),
    .full   (full),
    .rce    (rce),
    .rq     (rq),
    .rvalid (rvalid),
    .empty  (empty),
    .level  (level),
    .err_ovf(err_ovf),
    .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // Reference model: the unread lanes in order, plus the observable registers.
  logic [RD_WIDTH-1:0] q[$];
  logic [RD_WIDTH-1:0] m_rq;
  logic                m_rvalid, m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int words_held();
    return (q.size() + RATIO - 1) / RATIO;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rq     = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rq"},     32'(rq),      32'(m_rq));
    chk({tag, ".rvalid"}, 32'(rvalid),  32'(m_rvalid));
    chk({tag, ".level"},  32'(level),   32'(q.size()));
    chk({tag, ".full"},   32'(full),    32'(words_held() == WR_DEPTH));
    chk({tag, ".empty"},  32'(empty),   32'(q.size() == 0));
    chk({tag, ".ovf"},    32'(err_ovf), 32'(m_ovf));
    chk({tag, ".udf"},    32'(err_udf), 32'(m_udf));
  endtask

  // One clock: drive, advance past the edge, update the model from pre-edge state, compare.
  task automatic step(input string tag, input logic w, input logic [WR_WIDTH-1:0] d,
                      input logic r);
    logic was_full, was_empty;
    was_full  = (words_held() == WR_DEPTH);
    was_empty = (q.size() == 0);
    wce = w;
    wd  = d;
    rce = r;
    @(posedge clk);
    #1;
    wce = 1'b0;
    rce = 1'b0;
    m_rvalid = 1'b0;
    if (r && !was_empty) begin
      m_rq     = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (r && was_empty) m_udf = 1'b1;
    if (w && !was_full) begin
      for (int k = 0; k < RATIO; k++) q.push_back(d[k*RD_WIDTH +: RD_WIDTH]);
    end
    if (w && was_full) m_ovf = 1'b1;
    check_all(tag);
  endtask

  task automatic random_run(input string tag, input int n_words, input int max_cycles);
    int wr_cnt = 0;
    int cyc    = 0;
    logic w, r;
    while (wr_cnt < n_words && cyc < max_cycles) begin
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) != 0);
      if (w && words_held() < WR_DEPTH) wr_cnt++;
      step(tag, w, $urandom, r);
      cyc++;
    end
    chk({tag, ".budget"}, 32'(wr_cnt), 32'(n_words));
  endtask

  initial begin
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset");

    // Lane order of a single word.
    step("t1.wr", 1'b1, 32'h4433_2211, 1'b0);
    chk("t1.lvl4", 32'(level), 32'd4);
    step("t1.r0", 1'b0, '0, 1'b1);
    chk("t1.b0", 32'(rq), 32'h11);
    step("t1.r1", 1'b0, '0, 1'b1);
    step("t1.r2", 1'b0, '0, 1'b1);
    step("t1.r3", 1'b0, '0, 1'b1);
    chk("t1.b3", 32'(rq), 32'h44);
    chk("t1.empty", 32'(empty), 32'd1);

    // Read on empty: no data update, sticky underflow.
    step("udf", 1'b0, '0, 1'b1);
    chk("udf.flag", 32'(err_udf), 32'd1);

    // Fill to capacity, then one dropped write.
    for (int i = 0; i < WR_DEPTH; i++) step("fill", 1'b1, 32'h1000_0000 + 32'(i * 7), 1'b0);
    chk("fill.lvl", 32'(level), 32'd4096);
    chk("fill.full", 32'(full), 32'd1);
    step("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf.flag", 32'(err_ovf), 32'd1);
    chk("ovf.lvl", 32'(level), 32'd4096);

    // Slot frees only after the last lane of the head word.
    step("pf.r0", 1'b0, '0, 1'b1);
    chk("pf.full1", 32'(full), 32'd1);
    chk("pf.lvl", 32'(level), 32'd4095);
    step("pf.r1", 1'b0, '0, 1'b1);
    step("pf.r2", 1'b0, '0, 1'b1);
    step("pf.r3", 1'b0, '0, 1'b1);
    chk("pf.full0", 32'(full), 32'd0);
    step("pf.wr", 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("pf.refull", 32'(full), 32'd1);

    // Completing read while full: same-cycle write still rejected.
    step("cw.r0", 1'b0, '0, 1'b1);
    step("cw.r1", 1'b0, '0, 1'b1);
    step("cw.r2", 1'b0, '0, 1'b1);
    step("cw.both", 1'b1, 32'h0BAD_0BAD, 1'b1);
    chk("cw.lvl", 32'(level), 32'd4092);

    // Drain to one lane, then simultaneous write and read.
    while (q.size() > 1) step("drain", 1'b0, '0, 1'b1);
    step("sim.both", 1'b1, 32'hDDCC_BBAA, 1'b1);
    chk("sim.lvl", 32'(level), 32'd4);
    step("sim.r0", 1'b0, '0, 1'b1);
    chk("sim.aa", 32'(rq), 32'hAA);
    step("sim.r1", 1'b0, '0, 1'b1);
    step("sim.r2", 1'b0, '0, 1'b1);
    step("sim.r3", 1'b0, '0, 1'b1);
    chk("sim.dd", 32'(rq), 32'hDD);

    // Long random stream across pointer wrap.
    random_run("rnd", 3000, 40000);
    while (q.size() > 0) step("rdrain", 1'b0, '0, 1'b1);

    // Asynchronous reset between edges, mid-stream.
    random_run("pre", 60, 2000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    #4 rst_n = 1'b1;
    step("post.wr", 1'b1, 32'h5566_7788, 1'b0);
    step("post.rd", 1'b0, '0, 1'b1);
    chk("post.lane0", 32'(rq), 32'h88);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wide_wr_narrow_rd.md
Name: fifo_wide_wr_narrow_rd

Overview:
- Synchronous single-clock FIFO with asymmetric ports: wide words are written, narrow sub-words are read.
- The read side unpacks each stored word into RATIO lanes, lowest lane first.
- It is the unpacking counterpart to the narrow-write/wide-read packing memories; it feeds byte-serial consumers (e.g. a UART/SPI shifter) from a 32-bit producer.
- Storage is sized to map onto a single BRAM macro at defaults.

Parameters:
- WR_WIDTH, 32, width of write word; must be RATIO * RD_WIDTH.
- RATIO, 4, narrow lanes per wide word; power of 2, at least 2.
- RD_WIDTH, WR_WIDTH/RATIO, read data width; derived, not overridden.
- WR_DEPTH, 1024, wide-word capacity; power of 2.
- LVL_W, $clog2(WR_DEPTH*RATIO)+1, width of level.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wce  in  1  write request.
- wd  in  WR_WIDTH  write word; lane k = wd[k*RD_WIDTH +: RD_WIDTH].
- full  out  1  no free word slot.
- rce  in  1  read request.
- rq  out  RD_WIDTH  registered read data.
- rvalid  out  1  rq updated this cycle by an accepted read.
- empty  out  1  no unread lanes.
- level  out  LVL_W  unread lanes (narrow units).
- err_ovf  out  1  sticky: write attempted while full.
- err_udf  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr, rd_word, rd_lane = 0; rq = 0; rvalid = 0; level = 0; empty = 1; full = 0; err flags = 0. Memory contents are not cleared. Any in-flight read is discarded.
- Pointers carry one extra wrap bit. word_occ = wr_ptr - rd_word. A partially read word counts as occupied.
- full = (word_occ == WR_DEPTH). empty = (level == 0). Both are combinational from registered state.
- Write accept: wce && !full. mem[wr_ptr] <= wd; wr_ptr+1, wrapping modulo WR_DEPTH.
- Write while full: dropped, state unchanged, err_ovf <= 1.
- Read accept: rce && !empty.
  - Next cycle: rq = lane rd_lane of mem[rd_word], rvalid = 1. Latency is 1 cycle.
  - rd_lane increments. At RATIO-1, rd_lane wraps to 0 and rd_word increments (wraps modulo WR_DEPTH).
- Read while empty: rvalid = 0 next cycle, rq holds, err_udf <= 1.
- rq holds its last value whenever no read is accepted. rvalid is high exactly one cycle per accepted read.
- level update: +RATIO per accepted write, -1 per accepted read. Simultaneous accept gives net +RATIO-1.
- Simultaneous write and read:
  - Both are evaluated against pre-edge flags.
  - A write to an empty FIFO is readable from the next cycle (empty falls one cycle after the write).
  - A read completing the last lane of a word while full frees the slot from the next cycle; the same-cycle write is still rejected.
- Read-during-write to the same word address cannot occur: empty or partial-word state prevents it.
- Error flags clear only on reset.
- Memory is inferred as one write port WR_WIDTH × WR_DEPTH. The read port selects rd_word, then the lane mux. The output register is the BRAM output register.

Test Plan:
- Write 0x44332211, then rce for 4 consecutive cycles -> rq = 0x11, 0x22, 0x33, 0x44 on the cycles after each rce; rvalid high 4 cycles; level 4→0; empty = 1 after the last read.
- Write 1024 distinct words -> full = 1, level = 4096. A 1025th write -> dropped, err_ovf = 1, level still 4096.
- From full, read 1 lane -> full stays 1, level = 4095. Read 3 more -> full = 0 the following cycle. A write then succeeds and full = 1 again.
- With level = 1, assert wce (0xDDCCBBAA) and rce in the same cycle -> old lane output; level = 4; next reads yield 0xAA, 0xBB, 0xCC, 0xDD.
- rce on empty after reset -> rvalid = 0, rq = 0, err_udf = 1. Stream 3000 words through with random wce/rce -> byte sequence matches the scoreboard across pointer wrap.
- Pulse rst_n low mid-stream, asynchronously between edges -> all outputs at reset values immediately; the next read after 1 new write returns lane 0 of the new word.
